// File: rtl/ad_spi_slave_if.sv
// SPI pin and register-commit bundle for ad_spi_slave.
// The slave modport is the block's view; master is the driving side (pads / bench).
interface ad_spi_slave_if;
   logic       i_ad_reset;
   logic       i_ad_sen;
   logic       i_ad_spi_clk;
   logic       i_ad_mosi;
   logic       o_ad_miso;
   logic       o_ad_miso_oe;
   logic       o_reg_wr;
   logic [6:0] o_reg_addr;
   logic [7:0] o_reg_wdata;
   logic       o_frame_err;
   logic       o_busy;

   modport slave (
      input  i_ad_reset, i_ad_sen, i_ad_spi_clk, i_ad_mosi,
      output o_ad_miso, o_ad_miso_oe, o_reg_wr, o_reg_addr, o_reg_wdata, o_frame_err, o_busy
   );

   modport master (
      output i_ad_reset, i_ad_sen, i_ad_spi_clk, i_ad_mosi,
      input  o_ad_miso, o_ad_miso_oe, o_reg_wr, o_reg_addr, o_reg_wdata, o_frame_err, o_busy
   );
endinterface

// File: rtl/ad_spi_slave.sv
// Oversampled 16-bit SPI register slave (mode 0): R/W + 7-bit address + 8-bit data per frame,
// with a small register file, soft reset via reg 0 bit 1 and a hardware reset pin.
module ad_spi_slave #(
   parameter int unsigned SYNC_STG = 2,
   parameter int unsigned REG_NUM  = 32
) (
   input  logic          sys_clk,
   input  logic          rst_n,
   ad_spi_slave_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StCmd, StData, StEnd} state_e;

   // Synchronizer lanes: {reset, sen, sclk, mosi}
   logic [SYNC_STG-1:0][3:0] sync_q;
   logic [3:0]               sync_s;
   logic                     sen_prev_q, sclk_prev_q;
   logic                     hw_rst, sen_s, sclk_s, mosi_s;
   logic                     sen_rise, sen_fall, sclk_rise, sclk_fall;

   state_e      state_q;
   logic [4:0]  bit_cnt_q;
   logic [15:0] sin_q;
   logic [7:0]  sout_q;
   logic        oe_q, busy_q, rd_load_q;
   logic        reg_wr_q, frame_err_q;
   logic [6:0]  addr_q;
   logic [7:0]  wdata_q;
   logic [7:0]  regs_q [REG_NUM];
   logic [7:0]  rd_val;
   logic        soft_rst;

   assign sync_s    = sync_q[SYNC_STG-1];
   assign hw_rst    = sync_s[3];
   assign sen_s     = sync_s[2];
   assign sclk_s    = sync_s[1];
   assign mosi_s    = sync_s[0];
   assign sen_rise  = sen_s & ~sen_prev_q;
   assign sen_fall  = ~sen_s & sen_prev_q;
   assign sclk_rise = sclk_s & ~sclk_prev_q;
   assign sclk_fall = ~sclk_s & sclk_prev_q;

   // Flops reset to 0, so a sen already low at reset release produces no falling edge.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q      <= '0;
         sen_prev_q  <= 1'b0;
         sclk_prev_q <= 1'b0;
      end else begin
         sync_q      <= {sync_q[SYNC_STG-2:0],
                         {bus.i_ad_reset, bus.i_ad_sen, bus.i_ad_spi_clk, bus.i_ad_mosi}};
         sen_prev_q  <= sen_s;
         sclk_prev_q <= sclk_s;
      end
   end

   // After 8 bits, sin_q[7] is R/W and sin_q[6:0] the address.
   always_comb begin
      rd_val = 8'h00;
      for (int unsigned i = 0; i < REG_NUM; i++) begin
         if (sin_q[6:0] == 7'(i)) rd_val = regs_q[i];
      end
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         bit_cnt_q   <= 5'd0;
         sin_q       <= 16'h0000;
         sout_q      <= 8'h00;
         oe_q        <= 1'b0;
         busy_q      <= 1'b0;
         rd_load_q   <= 1'b0;
         reg_wr_q    <= 1'b0;
         frame_err_q <= 1'b0;
         addr_q      <= 7'h00;
         wdata_q     <= 8'h00;
      end else begin
         reg_wr_q    <= 1'b0;
         frame_err_q <= 1'b0;
         rd_load_q   <= 1'b0;
         if (hw_rst) begin
            state_q   <= StIdle;
            bit_cnt_q <= 5'd0;
            sin_q     <= 16'h0000;
            sout_q    <= 8'h00;
            oe_q      <= 1'b0;
            busy_q    <= 1'b0;
         end else if (sen_rise) begin
            if (state_q != StIdle) begin
               if (bit_cnt_q != 5'd16) begin
                  frame_err_q <= 1'b1;
               end else if (!sin_q[15]) begin
                  reg_wr_q <= 1'b1;
                  addr_q   <= sin_q[14:8];
                  wdata_q  <= sin_q[7:0];
               end
            end
            state_q <= StIdle;
            sout_q  <= 8'h00;
            oe_q    <= 1'b0;
            busy_q  <= 1'b0;
         end else if (sen_fall) begin
            state_q   <= StCmd;
            bit_cnt_q <= 5'd0;
            sin_q     <= 16'h0000;
            sout_q    <= 8'h00;
            oe_q      <= 1'b0;
            busy_q    <= 1'b1;
         end else begin
            if (sclk_rise && state_q != StIdle) begin
               if (bit_cnt_q < 5'd16) sin_q <= {sin_q[14:0], mosi_s};
               if (bit_cnt_q != 5'd31) bit_cnt_q <= bit_cnt_q + 5'd1;
               case (state_q)
                  StCmd: begin
                     if (bit_cnt_q == 5'd7) begin
                        state_q   <= StData;
                        rd_load_q <= sin_q[6];
                     end
                  end
                  StData:  if (bit_cnt_q == 5'd15) state_q <= StEnd;
                  default: ;
               endcase
            end
            // Shift only on falls after rises 9..15 so the master samples bit 7 at rise 9.
            if (rd_load_q) begin
               sout_q <= rd_val;
               oe_q   <= 1'b1;
            end else if (sclk_fall && oe_q && bit_cnt_q >= 5'd9 && bit_cnt_q <= 5'd15) begin
               sout_q <= {sout_q[6:0], 1'b0};
            end
         end
      end
   end

   assign soft_rst = reg_wr_q && (addr_q == 7'h00) && wdata_q[1];

   // Writes land one cycle after the commit pulse; out-of-range addresses match no entry.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < REG_NUM; i++) regs_q[i] <= 8'h00;
      end else begin
         for (int unsigned i = 0; i < REG_NUM; i++) begin
            if (hw_rst || soft_rst) regs_q[i] <= 8'h00;
            else if (reg_wr_q && addr_q == 7'(i)) regs_q[i] <= wdata_q;
         end
      end
   end

   assign bus.o_ad_miso    = sout_q[7];
   assign bus.o_ad_miso_oe = oe_q;
   assign bus.o_reg_wr     = reg_wr_q;
   assign bus.o_reg_addr   = addr_q;
   assign bus.o_reg_wdata  = wdata_q;
   assign bus.o_frame_err  = frame_err_q;
   assign bus.o_busy       = busy_q;

endmodule
